// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - core-to-data-memory request/response bundle
interface data_mem_ctrl_if;
  // request path (core -> memory stage)
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        valid;
  logic        wen;
  logic        byte_not_word;
  // response path (memory stage -> core) plus core's response accept
  logic        core_yumi;
  logic        yumi;
  logic        resp_valid;
  logic [31:0] read_data;
  logic        misalign;
  logic        range_err;

  modport master (
    output addr, write_data, valid, wen, byte_not_word, core_yumi,
    input  yumi, resp_valid, read_data, misalign, range_err
  );

  modport slave (
    input  addr, write_data, valid, wen, byte_not_word, core_yumi,
    output yumi, resp_valid, read_data, misalign, range_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - data-memory stage with fixed-latency byte-addressable SRAM model
module data_mem_ctrl #(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 2
) (
  input  logic           clk,
  input  logic           reset,
  data_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int         words_lp    = 1 << addr_width_p;
  localparam logic [3:0] cnt_init_lp = 4'(latency_p - 1);

  logic [31:0] mem [words_lp];

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [addr_width_p-1:0] idx_q, idx_d;
  logic [1:0]              lane_q, lane_d;
  logic [31:0]             data_q, data_d;
  logic                    wen_q, wen_d;
  logic                    byte_q, byte_d;
  logic                    valid_q, valid_d;
  logic [31:0]             read_data_q, read_data_d;
  logic                    misalign_q, misalign_d;
  logic                    range_err_q, range_err_d;

  logic        accept;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;

  // Next-state and datapath: accept in IDLE, count down in BUSY, access on the last BUSY cycle, hold in RESP
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    data_d      = data_q;
    wen_d       = wen_q;
    byte_d      = byte_q;
    valid_d     = valid_q;
    read_data_d = read_data_q;
    misalign_d  = 1'b0;
    range_err_d = 1'b0;
    accept      = 1'b0;
    mem_we      = 1'b0;
    mem_rdata   = mem[idx_q];
    mem_wdata   = mem_rdata;

    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          accept      = 1'b1;
          // high address bits beyond the array are dropped, so the index wraps
          idx_d       = bus.addr[addr_width_p+1:2];
          // word accesses are forced onto lane 0 regardless of the low address bits
          lane_d      = bus.byte_not_word ? bus.addr[1:0] : 2'b00;
          data_d      = bus.write_data;
          wen_d       = bus.wen;
          byte_d      = bus.byte_not_word;
          cnt_d       = cnt_init_lp;
          state_d     = BUSY;
          misalign_d  = !bus.byte_not_word && (bus.addr[1:0] != 2'b00);
          range_err_d = |(bus.addr >> (addr_width_p + 2));
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          valid_d = 1'b1;
          if (wen_q) begin
            // stores hand back the word as it was before this write
            mem_we      = 1'b1;
            read_data_d = mem_rdata;
            if (byte_q) begin
              mem_wdata[{lane_q, 3'b000} +: 8] = data_q[7:0];
            end else begin
              mem_wdata = data_q;
            end
          end else if (byte_q) begin
            read_data_d = {24'h000000, mem_rdata[{lane_q, 3'b000} +: 8]};
          end else begin
            read_data_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // returning to IDLE forces a one-cycle bubble before the next accept
        if (bus.core_yumi) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Control, request latches and registered outputs; reset drops any in-flight request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      lane_q      <= 2'b00;
      data_q      <= 32'h0;
      wen_q       <= 1'b0;
      byte_q      <= 1'b0;
      valid_q     <= 1'b0;
      read_data_q <= 32'h0;
      misalign_q  <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      data_q      <= data_d;
      wen_q       <= wen_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      read_data_q <= read_data_d;
      misalign_q  <= misalign_d;
      range_err_q <= range_err_d;
    end
  end

  // SRAM write port; array contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= mem_wdata;
    end
  end

  assign bus.yumi       = accept;
  assign bus.resp_valid = valid_q;
  assign bus.read_data  = read_data_q;
  assign bus.misalign   = misalign_q;
  assign bus.range_err  = range_err_q;

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Data-memory stage directly downstream of the pipelined core.
- Consumes the core's request bundle (address, write data, valid, wen, byte_not_word, yumi) and produces its response bundle (yumi, valid, read_data).
- Holds a word-organised, byte-addressable SRAM model with a fixed, parameterised access latency.
- Uses a valid/yumi handshake on the request path and on the response path.

Parameters:
- addr_width_p, 10, word-index width; the memory holds 2^addr_width_p 32-bit words.
- latency_p, 2, number of BUSY cycles between request acceptance and response. Legal values are 1 to 15.

Ports:
- clk  in  1  core clock; everything is sampled on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr_i  in  32  byte address (the core's data_mem_addr).
- write_data_i  in  32  store data; byte stores use bits [7:0].
- valid_i  in  1  core request valid.
- wen_i  in  1  1 = store, 0 = load.
- byte_not_word_i  in  1  1 = byte access, 0 = word access.
- core_yumi_i  in  1  core accepts the current response.
- yumi_o  out  1  request accepted this cycle (combinational).
- valid_o  out  1  response valid.
- read_data_o  out  32  load result. For stores it returns the old word.
- misalign_o  out  1  one-cycle pulse: accepted word access with addr_i[1:0] != 0.
- range_err_o  out  1  one-cycle pulse: accepted access with addr_i[31:addr_width_p+2] != 0.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, cnt = 0, valid_o = 0, read_data_o = 0, misalign_o = 0, range_err_o = 0.
  - Request latches are cleared. Memory array contents are not reset.
- Address decode:
  - Word index = addr[addr_width_p+1:2]; lane = addr[1:0].
  - Word accesses ignore lane; they are force-aligned and misalign_o pulses.
  - Out-of-range addresses wrap modulo the array size; range_err_o pulses.
  - Both error pulses assert in the cycle after acceptance.
- State IDLE:
  - yumi_o = valid_i.
  - On valid_i: latch address, data, wen and byte flag; cnt <= latency_p-1; go to BUSY.
- State BUSY:
  - yumi_o = 0; valid_i is ignored and the core must hold it.
  - If cnt == 0, perform the access and go to RESP. Otherwise cnt <= cnt-1.
  - Word load: read_data_o <= mem[idx].
  - Byte load: read_data_o <= {24'b0, mem[idx][8*lane +: 8]} (zero-extended, little-endian lanes).
  - Word store: mem[idx] <= data.
  - Byte store: only lane bits written with data[7:0]; other lanes unchanged.
  - On a store, read_data_o <= pre-write word.
- State RESP:
  - valid_o = 1. read_data_o is held stable until the handshake.
  - core_yumi_i & valid_o: go to IDLE and valid_o <= 0.
  - A new request can be accepted no earlier than the next cycle (one bubble).
  - yumi_o = 0.
- Timing:
  - Accept edge at cycle T; valid_o is first high in cycle T+latency_p+1.
  - For latency_p = 2: accept in cycle 0, BUSY in cycles 1-2, valid_o in cycle 3.
- Ordering: strictly one outstanding request. A read after a write to the same word returns the new data.
- Simultaneous events:
  - core_yumi_i while not in RESP is ignored.
  - valid_i and core_yumi_i both high in RESP: only the response completes; the request waits.
- Reset mid-operation: an in-flight store that has not reached its access cycle is discarded (memory unchanged); the pending response is dropped.
- Write/read arithmetic: byte lanes are never sign-extended; cnt width = 4 bits.

Test Plan:
- Word store, then load:
  - Store 0xDEADBEEF at addr 0x10; then load addr 0x10 (latency_p = 2).
  - yumi_o is high in the request cycle; valid_o is high 3 cycles later; load read_data_o = 0xDEADBEEF.
- Byte store and byte loads:
  - Word-store 0x11223344 at 0x20; byte-store 0xAA at 0x22.
  - Word load 0x20 returns 0x11AA3344.
  - Byte load 0x23 returns 0x00000011.
  - Byte load 0x22 returns 0x000000AA.
- Response backpressure:
  - Load with core_yumi_i held low 5 cycles after valid_o.
  - valid_o and read_data_o stay stable for all 5 cycles.
  - yumi_o stays 0 even with a second valid_i pending.
  - After yumi: valid_o falls; the second request is accepted the next cycle.
- Errors:
  - Word load at 0x13: misalign_o pulses once; data returned is from word 0x10.
  - Load at 0x00001010 with addr_width_p = 10: range_err_o pulses; data returned is from word index 4.
- Reset mid-operation:
  - Store 0x55 to 0x40 (prior value 0x0) and assert reset during BUSY.
  - All outputs return to 0 immediately (asynchronous).
  - A subsequent load of 0x40 returns 0x0.
- Latency sweep: latency_p = 1 and latency_p = 15 -> valid_o first high at T+2 and T+16 respectively.
